// File: rtl/mips_pkg.sv
// Purpose: shared MDU constants: funct codes, FSM state enum, widths, magnitude helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mips_pkg;

  localparam int XLEN      = 32;
  localparam int MDU_ITERS = 32;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Absolute value when the operand is interpreted as signed, pass-through otherwise.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Purpose: restoring unsigned divider on operand magnitudes, one quotient bit per i_step.
// Latency: 32 steps after i_load; o_quo/o_rem valid once the last step has been taken.
// Backpressure: none; the caller sequences i_load/i_step.
// Ports: clk, rst_n (async active-low); i_load latches i_dividend/i_divisor;
//        i_step runs one iteration; o_quo/o_rem are the running quotient/remainder.
module mdu_divider
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;

  // Partial remainder shifted left with the next dividend bit (the dividend
  // bits are consumed from the top of r_quo while quotient bits enter below).
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge    = ~w_diff[XLEN+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      // Divide by zero falls out naturally: every subtraction succeeds, so the
      // quotient fills with ones and the remainder collects the dividend.
      r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_ge};
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/mdu.sv
// Purpose: MIPS multiply/divide unit with HI/LO; shift-add multiply, optional divide (MDU_DIV_EN).
// Latency: start accepted at edge 0, hi/lo written and done pulsed at edge 33; MTHI/MTLO in one edge.
// Backpressure: busy high in CALC/DONE; start ignored while busy; flush aborts CALC.
// Ports: clk, rst_n (async active-low), start, f (funct), rs_val, rt_val, flush;
//        busy, done, hi, lo. Macro MDU_DIV_EN adds the DIV/DIVU path.
module mdu
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      f,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [5:0] CNT_LAST = 6'(MDU_ITERS);

  mdu_state_t        r_state, w_state_nxt;
  logic [5:0]        r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic              r_neg;
  logic [XLEN-1:0]   r_hi, r_lo;

  logic              w_is_mul, w_is_div, w_mul_signed;
  logic              w_accept, w_iter, w_finish;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_res;
  logic [XLEN-1:0]   w_res_hi, w_res_lo;

  assign w_is_mul     = (f == FN_MULT) || (f == FN_MULTU);
  assign w_mul_signed = (f == FN_MULT);
  assign w_accept     = (r_state == IDLE) && start && (w_is_mul || w_is_div);
  // Edges 1..32 iterate; edge 33 (counter at 32) applies sign fix-up and commits.
  assign w_iter       = (r_state == CALC) && !flush && (r_cnt != CNT_LAST);
  assign w_finish     = (r_state == CALC) && !flush && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (flush)                  w_state_nxt = IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Radix-2 shift-add on magnitudes: low half holds the unconsumed multiplier,
  // high half accumulates; each step adds the multiplicand if the LSB is set.
  assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_res = r_neg ? -r_prod : r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_prod  <= {{XLEN{1'b0}}, mag(rt_val, w_mul_signed)};
      r_mcand <= mag(rs_val, w_mul_signed);
      r_neg   <= w_mul_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
    end else if (w_iter) begin
      r_cnt   <= r_cnt + 6'd1;
      r_prod  <= {w_mul_sum, r_prod[XLEN-1:1]};
    end
  end

`ifdef MDU_DIV_EN
  logic            w_div_signed;
  logic [XLEN-1:0] w_quo, w_rem, w_div_q, w_div_r;
  logic            r_is_div, r_negq, r_negr, r_dz;
  logic [XLEN-1:0] r_rs;

  assign w_is_div     = (f == FN_DIV) || (f == FN_DIVU);
  assign w_div_signed = (f == FN_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_dz     <= 1'b0;
      r_rs     <= '0;
    end else if (w_accept) begin
      r_is_div <= w_is_div;
      r_negq   <= w_div_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
      r_negr   <= w_div_signed && rs_val[XLEN-1];
      r_dz     <= (rt_val == '0);
      r_rs     <= rs_val;
    end
  end

  mdu_divider u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept && w_is_div),
    .i_step     (w_iter && r_is_div),
    .i_dividend (mag(rs_val, w_div_signed)),
    .i_divisor  (mag(rt_val, w_div_signed)),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  assign w_div_q = r_negq ? -w_quo : w_quo;
  assign w_div_r = r_negr ? -w_rem : w_rem;
  // Divide by zero bypasses sign fix-up so signed and unsigned agree.
  assign w_res_lo = !r_is_div ? w_mul_res[XLEN-1:0]      : (r_dz ? '1   : w_div_q);
  assign w_res_hi = !r_is_div ? w_mul_res[2*XLEN-1:XLEN] : (r_dz ? r_rs : w_div_r);
`else
  assign w_is_div = 1'b0;
  assign w_res_lo = w_mul_res[XLEN-1:0];
  assign w_res_hi = w_mul_res[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if ((r_state == IDLE) && start) begin
      if (f == FN_MTHI) r_hi <= rs_val;
      if (f == FN_MTLO) r_lo <= rs_val;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Purpose: directed self-checking bench for mdu (multiply, MTHI/MTLO, flush, reset, divide gating).
// Latency: checks acceptance at edge 0, done/hi/lo at edge 33, idle at edge 34.
// Backpressure: checks start is ignored while busy and flush only acts in CALC.
module tb_mdu;

  localparam logic [5:0] T_MULT  = 6'b011000;
  localparam logic [5:0] T_MULTU = 6'b011001;
  localparam logic [5:0] T_DIV   = 6'b011010;
  localparam logic [5:0] T_DIVU  = 6'b011011;
  localparam logic [5:0] T_MTHI  = 6'b010001;
  localparam logic [5:0] T_MTLO  = 6'b010011;
  localparam logic [5:0] T_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [5:0]  f;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic seen_done;

  always #5 clk = ~clk;

  mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .f      (f),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with latency checks; operands are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic fl,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; f = fn; rs_val = a; rt_val = b; flush = fl;
    tick();
    start = 1'b0; flush = 1'b0; rs_val = $urandom; rt_val = $urandom;
    chk({tag, " busy@0"}, {31'b0, busy}, 32'd1);
    chk({tag, " done@0"}, {31'b0, done}, 32'd0);
    repeat (32) tick();
    chk({tag, " busy@32"}, {31'b0, busy}, 32'd1);
    chk({tag, " done@32"}, {31'b0, done}, 32'd0);
    tick();
    chk({tag, " done@33"}, {31'b0, done}, 32'd1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    tick();
    chk({tag, " done@34"}, {31'b0, done}, 32'd0);
    chk({tag, " busy@34"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic mt(input string tag, input logic [5:0] fn, input logic [31:0] a,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; f = fn; rs_val = a;
    tick();
    start = 1'b0;
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; f = '0; rs_val = '0; rt_val = '0;
    #12;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First edge after reset release accepts the request.
    run_op("mult_neg",  T_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_nn",   T_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'h0,        32'h6);
    run_op("mult_min",  T_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0);
    run_op("multu_sh",  T_MULTU, 32'h12345678, 32'h10,       1'b0, 32'h1,        32'h23456780);
    // flush together with start in IDLE: start wins.
    run_op("mult_flidle", T_MULT, 32'd3, 32'hFFFFFFFB, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);

    mt("mtlo", T_MTLO, 32'h00001234, 32'hFFFFFFFF, 32'h00001234);
    mt("mthi", T_MTHI, 32'hABCD0000, 32'hABCD0000, 32'h00001234);

    // MTHI held on start throughout CALC and DONE must not touch hi.
    start = 1'b1; f = T_MULT; rs_val = 32'd2; rt_val = 32'd3;
    tick();
    f = T_MTHI; rs_val = 32'hDEADBEEF;
    repeat (33) tick();
    chk("mthi_calc done", {31'b0, done}, 32'd1);
    chk("mthi_calc hi", hi, 32'h0);
    chk("mthi_calc lo", lo, 32'h6);
    tick();
    start = 1'b0;
    chk("mthi_done hi", hi, 32'h0);
    chk("mthi_done busy", {31'b0, busy}, 32'd0);

    // Unrecognised funct is ignored.
    start = 1'b1; f = T_ADD; rs_val = 32'h55555555; rt_val = 32'h1;
    tick();
    start = 1'b0;
    chk("badf busy", {31'b0, busy}, 32'd0);
    tick();
    chk("badf busy2", {31'b0, busy}, 32'd0);
    chk("badf hi", hi, 32'h0);
    chk("badf lo", lo, 32'h6);

`ifdef MDU_DIV_EN
    run_op("div_neg",  T_DIV,  32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_z",   T_DIVU, 32'd5,        32'd0,        1'b0, 32'd5,        32'hFFFFFFFF);
    run_op("div_ovf",  T_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h80000000);
    run_op("div_z",    T_DIV,  32'hFFFFFFF9, 32'd0,        1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divu_big", T_DIVU, 32'hFFFFFFFF, 32'd16,       1'b0, 32'hF,        32'h0FFFFFFF);
`else
    // Divide path absent: DIV/DIVU behave as unrecognised functs.
    start = 1'b1; f = T_DIV; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
    tick();
    f = T_DIVU;
    tick();
    start = 1'b0;
    chk("nodiv busy", {31'b0, busy}, 32'd0);
    tick();
    chk("nodiv busy2", {31'b0, busy}, 32'd0);
    chk("nodiv hi", hi, 32'h0);
    chk("nodiv lo", lo, 32'h6);
`endif

    mt("pre_hi", T_MTHI, 32'h11111111, 32'h11111111, lo);
    mt("pre_lo", T_MTLO, 32'h22222222, 32'h11111111, 32'h22222222);

    // Flush asserted for the edge at cycle 10 of CALC.
    seen_done = 1'b0;
    start = 1'b1; f = T_MULT; rs_val = 32'd5; rt_val = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush hi", hi, 32'h11111111);
    chk("flush lo", lo, 32'h22222222);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("flush no_done", {31'b0, seen_done}, 32'd0);
    chk("flush busy_late", {31'b0, busy}, 32'd0);
    chk("flush hi_late", hi, 32'h11111111);
    chk("flush lo_late", lo, 32'h22222222);

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; f = T_MULT; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("arst hi", hi, 32'h0);
    chk("arst lo", lo, 32'h0);
    chk("arst busy", {31'b0, busy}, 32'd0);
    chk("arst done", {31'b0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    run_op("post_rst", T_MULTU, 32'd6, 32'd7, 1'b0, 32'h0, 32'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-004 SHALL have port f, input, 6: MIPS R-type funct.
- MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
REQ-005 SHALL have port rs_val, input, 32: dividend, multiplicand, or MTHI/MTLO source.
REQ-006 SHALL have port rt_val, input, 32: divisor or multiplier.
REQ-007 SHALL have port flush, input, 1: synchronous abort of an in-flight operation.
REQ-008 SHALL have port busy, output, 1: high in CALC and DONE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high in DONE only.
REQ-010 SHALL have port hi, output, 32, and port lo, output, 32: architectural HI/LO registers.

Function
REQ-011 SHALL implement a three-state FSM.
- IDLE -> CALC: start=1 with f in {MULT, MULTU, DIV, DIVU}.
- CALC -> DONE: after exactly 32 iteration cycles.
- DONE -> IDLE: unconditionally after one cycle.
REQ-012 Latency SHALL be fixed.
- start accepted at edge 0.
- hi/lo updated at edge 33.
- done high from edge 33 to edge 34.
REQ-013 MULT/MULTU SHALL be radix-2 shift-add.
- Result: {hi,lo} = 64-bit product.
- MULT: signed operands; MULTU: unsigned operands.
REQ-014 DIV/DIVU SHALL be restoring division.
- Result: lo = quotient, hi = remainder.
- Signed divide works on magnitudes.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-015 Divide by zero SHALL give lo=32'hFFFFFFFF, hi=rs_val, for both DIV and DIVU.
REQ-016 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-017 Operands SHALL be latched at acceptance; rs_val/rt_val changes during CALC SHALL have no effect.
REQ-018 MTHI/MTLO with start=1 in IDLE SHALL write hi/lo (respectively) at the next edge.
- FSM stays in IDLE.
- busy and done stay 0.
REQ-019 start SHALL be ignored in CALC and DONE, including MTHI/MTLO.
REQ-020 start with an unrecognised f SHALL be ignored.
REQ-021 flush=1 in CALC SHALL force IDLE at the next edge.
- hi/lo keep their pre-operation values.
- done never pulses.
REQ-022 flush SHALL be ignored in IDLE and DONE.
REQ-023 If flush and start are both high in IDLE, start SHALL be accepted.

Reset
REQ-024 rst_n=0 SHALL asynchronously force the following, at any time including mid-CALC.
- state=IDLE, hi=0, lo=0.
- busy=0, done=0.
- iteration counter=0, internal accumulators=0.
REQ-025 After rst_n deassertion, start SHALL be accepted on the first rising edge.

Configuration
REQ-026 Macro MDU_DIV_EN SHALL control the divide path.
- Defined: DIV/DIVU behave per REQ-014..016.
- Undefined: divide hardware is absent; DIV/DIVU are treated as unrecognised (REQ-020); MULT/MULTU/MTHI/MTLO are unchanged.

Structure
REQ-027 Shared package mips_pkg SHALL hold:
- the funct code constants for MULT, MULTU, DIV, DIVU, MTHI, MTLO;
- the MDU state enum (IDLE, CALC, DONE);
- the data-width constant (32);
- the iteration-count constant (32).
REQ-028 A sub-module mdu_divider SHALL hold the restoring-divide datapath (one iteration per cycle).
- Instantiated only when MDU_DIV_EN is defined.
- The multiply path and FSM live in mdu.

Verification
REQ-029 MULT, rs=32'hFFFFFFFD, rt=7 -> done at edge 33, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-030 MULTU, rs=rt=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 DIV, rs=32'hFFFFFFF9 (-7), rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- Then DIVU rs=5, rt=0 -> lo=32'hFFFFFFFF, hi=5.
REQ-032 MULT started, flush at cycle 10 -> busy=0 one cycle later, hi/lo unchanged, done never high.
- Repeat with rst_n pulsed mid-CALC -> hi=lo=0 immediately.
REQ-033 MTLO rs=32'h00001234 in IDLE -> lo=32'h00001234 next edge, busy=done=0.
- MTHI issued during CALC -> hi unaffected.
REQ-034 With MDU_DIV_EN undefined, DIV start -> busy stays 0, hi/lo unchanged.
